controle_varredura_servo: RTL and testbench
===========================================

Name: controle_varredura_servo

Overview:
- Sequencer for the servo PWM block (`circuito_pwm`) in scan applications.
- After a start command, it moves the servo to position 0 and then sweeps 0→1→2→3→2→1→0… in a ping-pong pattern.
- At each position it waits a settle time, requests one measurement from the sensor subsystem, and waits for the result (with timeout) before stepping.
- It drives the servo block's `set_pos`/`pos_inicial`/`direita`/`esquerda`/`enable_mov` inputs and reads back its `pos` output.

Parameters:
- SETTLE_CICLOS, 25_000_000, clock cycles waited after position confirmed (500 ms at 50 MHz); must be ≥1.
- TIMEOUT_CICLOS, 5_000_000, maximum cycles waiting for `medida_pronta` (100 ms); must be ≥1.
- MOVE_MAX_CICLOS, 64, maximum cycles waiting for `pos` to reach target before flagging `erro_mov`.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- iniciar  in  1  level; sampled in OCIOSO, starts the sweep
- parar  in  1  level; stops at the next position boundary
- pos  in  2  current servo position (from the servo block `pos` output)
- medida_pronta  in  1  one-cycle pulse, measurement complete
- set_pos  out  1  load `pos_inicial` into the servo position counter
- pos_inicial  out  2  constant 2'b00
- direita  out  1  step +1 request (level, edge-detected downstream)
- esquerda  out  1  step −1 request
- enable_mov  out  1  enables servo position counter stepping
- medir  out  1  one-cycle measurement request pulse
- pos_medida  out  2  position tag of the current/last measurement
- amostra_valida  out  1  one-cycle pulse: measurement accepted at `pos_medida`
- timeout  out  1  one-cycle pulse: measurement timed out at `pos_medida`
- erro_mov  out  1  sticky; servo did not reach target within MOVE_MAX_CICLOS
- ativo  out  1  high in every state except OCIOSO and ERRO
- db_estado  out  4  state encoding for debug

Behaviour:
- Reset (synchronous, wins over every other input):
  - state = OCIOSO; all outputs 0; `sentido` = 1 (ascending); `alvo` = 0; timers = 0.
- OCIOSO:
  - `iniciar`=1 → ZERA_POS.
- ZERA_POS:
  - `set_pos`=1 for exactly 1 cycle; `alvo`←0.
  - Next cycle → CONFIRMA.
- MOVE:
  - `enable_mov`=1 throughout.
  - Cycle 1: `direita`=1 if `sentido`=1, else `esquerda`=1.
  - Cycle 2: both 0 (clean edge for the detector).
  - Then → CONFIRMA.
- CONFIRMA:
  - Movement counter increments each cycle.
  - `pos`==`alvo` → clear counter, → ESTABILIZA.
  - Counter reaches MOVE_MAX_CICLOS-1 → `erro_mov`=1, → ERRO.
- ESTABILIZA:
  - Settle counter counts 0..SETTLE_CICLOS-1, then → MEDE.
- MEDE:
  - `medir`=1 for 1 cycle; `pos_medida`←`alvo`; timeout counter cleared.
  - → AGUARDA.
- AGUARDA:
  - `medida_pronta`=1 → `amostra_valida` pulse next cycle, → PROXIMO.
  - Timeout counter reaches TIMEOUT_CICLOS-1 without it → `timeout` pulse, → PROXIMO.
  - If `medida_pronta` arrives on the same cycle as the terminal count, the measurement wins.
  - `medida_pronta` outside AGUARDA is ignored.
- PROXIMO:
  - `parar`=1 → OCIOSO; `alvo`, `sentido` and servo position are held.
  - Otherwise, direction turnaround:
    - At `alvo`=3 with `sentido`=1: `sentido`←0.
    - At `alvo`=0 with `sentido`=0: `sentido`←1.
  - Then `alvo`←`alvo`±1 using the updated `sentido` (2-bit, never wraps), → MOVE.
  - Sequence from power-up: 0,1,2,3,2,1,0,1…
- `parar` in any other state is only acted on in PROXIMO, so an in-flight measurement always completes.
- ERRO:
  - Holds until reset; `ativo`=0.
  - `iniciar` is ignored.
- `iniciar` held high after returning to OCIOSO restarts via ZERA_POS (position 0, `sentido`=1).

Optional Feature:
- Macro: `VARREDURA_UNIDIRECIONAL_EN`.
- Defined: sweep is 0,1,2,3,0,1… instead of ping-pong.
  - From `alvo`=3, PROXIMO goes to ZERA_POS, which issues `set_pos` (jump to 0); `sentido` stays 1.
  - `esquerda` is never asserted.
- Undefined: ping-pong as above.

Decomposition:
- Package `varredura_pkg`:
  - State encoding constants (4-bit): OCIOSO=0, ZERA_POS=1, MOVE=2, CONFIRMA=3, ESTABILIZA=4, MEDE=5, AGUARDA=6, PROXIMO=7, ERRO=15.
  - POS_MAX=2'd3.
- One sub-module, `temporizador_m`:
  - Parameterized M-cycle counter with `zera`/`conta`/`fim` ports.
  - Instantiated three times: settle, timeout, move.
- FSM plus `alvo`/`sentido` registers live in the top module.

Test Plan:
All scenarios use SETTLE_CICLOS=4, TIMEOUT_CICLOS=8, MOVE_MAX_CICLOS=6, and a behavioral servo model that updates `pos` 2 cycles after a `direita`/`esquerda` edge.
- Reset sweep: reset=1 for 2 cycles → all outputs 0, `db_estado`=0.
  - Then `iniciar`=1 → `set_pos` pulse, then `medir` after 4 settle cycles with `pos_medida`=0.
- Full ping-pong: `medida_pronta` returned 3 cycles after each `medir` → `amostra_valida` tags 0,1,2,3,2,1,0,1.
  - `esquerda` is first asserted after tag 3.
- Timeout: `medida_pronta` never driven at position 2 → `timeout` pulse exactly 8 cycles after `medir`, `pos_medida`=2.
  - Sweep continues to 3.
- Simultaneous: `medida_pronta` on the terminal timeout cycle → `amostra_valida`=1, `timeout`=0.
- Stop and move error: `parar`=1 during AGUARDA at position 1 → measurement completes, FSM returns to OCIOSO, `alvo`=1.
  - Servo model frozen → `erro_mov`=1 after 6 cycles in CONFIRMA; stays in ERRO until reset.
- Mid-operation reset: reset asserted in ESTABILIZA → next cycle OCIOSO, `medir` never issued, `sentido`=1.

Source files
------------

// File: rtl/varredura_pkg.sv
// Shared types and constants for the servo scan sequencer.
package varredura_pkg;

    typedef enum logic [3:0] {
        StOcioso     = 4'd0,
        StZeraPos    = 4'd1,
        StMove       = 4'd2,
        StConfirma   = 4'd3,
        StEstabiliza = 4'd4,
        StMede       = 4'd5,
        StAguarda    = 4'd6,
        StProximo    = 4'd7,
        StErro       = 4'd15
    } estado_e;

    localparam logic [1:0] POS_MIN = 2'd0;
    localparam logic [1:0] POS_MAX = 2'd3;

    // Ping-pong turnaround: reverse at either end of the range.
    function automatic logic vira_sentido(input logic [1:0] alvo, input logic sentido);
        logic novo;
        novo = sentido;
        if (alvo == POS_MAX && sentido) begin
            novo = 1'b0;
        end else if (alvo == POS_MIN && !sentido) begin
            novo = 1'b1;
        end
        return novo;
    endfunction

endpackage

// File: rtl/temporizador_m.sv
// M-cycle counter: clears on zera, advances on conta, fim flags the terminal count M-1.
module temporizador_m
    import varredura_pkg::*;
#(
    parameter int unsigned M = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int unsigned W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] valor_q;

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            valor_q <= '0;
        end else if (conta && !fim) begin
            valor_q <= valor_q + W'(1);
        end
    end

    assign fim = (valor_q == W'(M - 1));

endmodule

// File: rtl/controle_varredura_servo.sv
// Scan sequencer driving circuito_pwm: position, settle, measure, step.
// Define VARREDURA_UNIDIRECIONAL_EN for a 0,1,2,3,0,... sweep instead of ping-pong.
module controle_varredura_servo
    import varredura_pkg::*;
#(
    parameter int unsigned SETTLE_CICLOS   = 25_000_000,
    parameter int unsigned TIMEOUT_CICLOS  = 5_000_000,
    parameter int unsigned MOVE_MAX_CICLOS = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic [1:0] pos,
    input  logic       medida_pronta,
    output logic       set_pos,
    output logic [1:0] pos_inicial,
    output logic       direita,
    output logic       esquerda,
    output logic       enable_mov,
    output logic       medir,
    output logic [1:0] pos_medida,
    output logic       amostra_valida,
    output logic       timeout,
    output logic       erro_mov,
    output logic       ativo,
    output logic [3:0] db_estado
);

    estado_e    state_q, state_d;
    logic [1:0] alvo_q, alvo_d;
    logic       sentido_q, sentido_d;
    logic       fase_q, fase_d;
    logic [1:0] pos_medida_q, pos_medida_d;
    logic       amostra_q, amostra_d;
    logic       erro_q, erro_d;

    logic settle_fim, tmo_fim, mov_fim;

    temporizador_m #(.M(SETTLE_CICLOS)) u_settle (
        .clock (clock),
        .reset (reset),
        .zera  (state_q != StEstabiliza),
        .conta (state_q == StEstabiliza),
        .fim   (settle_fim)
    );

    temporizador_m #(.M(TIMEOUT_CICLOS)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (state_q != StAguarda),
        .conta (state_q == StAguarda),
        .fim   (tmo_fim)
    );

    temporizador_m #(.M(MOVE_MAX_CICLOS)) u_move (
        .clock (clock),
        .reset (reset),
        .zera  (state_q != StConfirma),
        .conta (state_q == StConfirma),
        .fim   (mov_fim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StOcioso;
            alvo_q       <= POS_MIN;
            sentido_q    <= 1'b1;
            fase_q       <= 1'b0;
            pos_medida_q <= 2'd0;
            amostra_q    <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            alvo_q       <= alvo_d;
            sentido_q    <= sentido_d;
            fase_q       <= fase_d;
            pos_medida_q <= pos_medida_d;
            amostra_q    <= amostra_d;
            erro_q       <= erro_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        alvo_d       = alvo_q;
        sentido_d    = sentido_q;
        fase_d       = 1'b0;
        pos_medida_d = pos_medida_q;
        amostra_d    = 1'b0;
        erro_d       = erro_q;
        set_pos      = 1'b0;
        direita      = 1'b0;
        esquerda     = 1'b0;
        enable_mov   = 1'b0;
        medir        = 1'b0;
        timeout      = 1'b0;

        unique case (state_q)
            StOcioso: begin
                if (iniciar) state_d = StZeraPos;
            end
            StZeraPos: begin
                set_pos   = 1'b1;
                alvo_d    = POS_MIN;
                sentido_d = 1'b1;
                state_d   = StConfirma;
            end
            StMove: begin
                enable_mov = 1'b1;
                // Pulse for one cycle then drop, so the downstream edge detector sees a clean edge.
                if (!fase_q) begin
                    fase_d  = 1'b1;
                    direita = sentido_q;
`ifdef VARREDURA_UNIDIRECIONAL_EN
                    esquerda = 1'b0;
`else
                    esquerda = !sentido_q;
`endif
                end else begin
                    state_d = StConfirma;
                end
            end
            StConfirma: begin
                if (pos == alvo_q) begin
                    state_d = StEstabiliza;
                end else if (mov_fim) begin
                    erro_d  = 1'b1;
                    state_d = StErro;
                end
            end
            StEstabiliza: begin
                if (settle_fim) state_d = StMede;
            end
            StMede: begin
                medir        = 1'b1;
                pos_medida_d = alvo_q;
                state_d      = StAguarda;
            end
            StAguarda: begin
                // A measurement landing on the terminal count still wins.
                if (medida_pronta) begin
                    amostra_d = 1'b1;
                    state_d   = StProximo;
                end else if (tmo_fim) begin
                    timeout = 1'b1;
                    state_d = StProximo;
                end
            end
            StProximo: begin
                if (parar) begin
                    state_d = StOcioso;
                end else begin
`ifdef VARREDURA_UNIDIRECIONAL_EN
                    if (alvo_q == POS_MAX) begin
                        state_d = StZeraPos;
                    end else begin
                        alvo_d  = alvo_q + 2'd1;
                        state_d = StMove;
                    end
`else
                    sentido_d = vira_sentido(alvo_q, sentido_q);
                    alvo_d    = sentido_d ? (alvo_q + 2'd1) : (alvo_q - 2'd1);
                    state_d   = StMove;
`endif
                end
            end
            StErro: begin
                state_d = StErro;
            end
            default: begin
                state_d = StOcioso;
            end
        endcase
    end

    assign pos_inicial    = POS_MIN;
    assign pos_medida     = pos_medida_q;
    assign amostra_valida = amostra_q;
    assign erro_mov       = erro_q;
    assign ativo          = (state_q != StOcioso) && (state_q != StErro);
    assign db_estado      = state_q;

endmodule

// File: tb/tb_controle_varredura_servo.sv
// Directed bench for controle_varredura_servo with a simple servo position model.
module tb_controle_varredura_servo;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       parar;
    logic [1:0] pos;
    logic       medida_pronta;
    logic       set_pos;
    logic [1:0] pos_inicial;
    logic       direita;
    logic       esquerda;
    logic       enable_mov;
    logic       medir;
    logic [1:0] pos_medida;
    logic       amostra_valida;
    logic       timeout;
    logic       erro_mov;
    logic       ativo;
    logic [3:0] db_estado;

    int n_chk = 0;
    int n_err = 0;
    int n_ev  = 0;
    int esq_idx = -1;

    // Servo model / responder controls
    logic freeze = 1'b0;
    logic resp_en = 1'b1;
    int   resp_delay = 3;

    logic       dir_prev = 1'b0;
    logic       esq_prev = 1'b0;
    logic       sobe = 1'b0;
    int         pend = 0;

    always #5 clock = ~clock;

    controle_varredura_servo #(
        .SETTLE_CICLOS   (4),
        .TIMEOUT_CICLOS  (8),
        .MOVE_MAX_CICLOS (6)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .parar          (parar),
        .pos            (pos),
        .medida_pronta  (medida_pronta),
        .set_pos        (set_pos),
        .pos_inicial    (pos_inicial),
        .direita        (direita),
        .esquerda       (esquerda),
        .enable_mov     (enable_mov),
        .medir          (medir),
        .pos_medida     (pos_medida),
        .amostra_valida (amostra_valida),
        .timeout        (timeout),
        .erro_mov       (erro_mov),
        .ativo          (ativo),
        .db_estado      (db_estado)
    );

    // Servo: position moves 2 cycles after a step-request rising edge; set_pos loads at once.
    initial pos = 2'd0;
    always @(posedge clock) begin
        dir_prev <= direita;
        esq_prev <= esquerda;
        if (set_pos) begin
            pos  <= pos_inicial;
            pend <= 0;
        end else if (!freeze && ((direita && !dir_prev) || (esquerda && !esq_prev))) begin
            pend <= 2;
            sobe <= direita;
        end else if (pend != 0) begin
            pend <= pend - 1;
            if (pend == 1) pos <= sobe ? pos + 2'd1 : pos - 2'd1;
        end
    end

    // Sensor: answers resp_delay cycles after the medir cycle.
    initial begin : responder
        medida_pronta = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            medida_pronta = 1'b0;
            if (medir && resp_en) begin
                repeat (resp_delay) @(posedge clock);
                #1;
                medida_pronta = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (esquerda && esq_idx < 0) esq_idx = n_ev;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, required done");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", tag, obs, exp);
        end
    endtask

    // kind: 1 = amostra_valida, 2 = timeout, 0 = nothing within the bound
    task automatic wait_evento(output int tag, output int kind);
        kind = 0;
        tag  = -1;
        for (int i = 0; i < 60 && kind == 0; i++) begin
            @(negedge clock);
            if (amostra_valida) kind = 1;
            else if (timeout)   kind = 2;
            if (kind != 0) tag = int'(pos_medida);
        end
        n_ev++;
    endtask

    task automatic wait_medir(output int achou);
        achou = 0;
        for (int i = 0; i < 60 && achou == 0; i++) begin
            @(negedge clock);
            if (medir) achou = 1;
        end
    endtask

    task automatic wait_estado(input int est, output int achou);
        achou = 0;
        for (int i = 0; i < 40 && achou == 0; i++) begin
            @(negedge clock);
            if (int'(db_estado) == est) achou = 1;
        end
    endtask

    int tags_pp [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

    initial begin : main
        int tag, kind, achou, cyc, cnt;

        reset   = 1'b1;
        iniciar = 1'b0;
        parar   = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst_db_estado", int'(db_estado), 0);
        check_eq("rst_set_pos", int'(set_pos), 0);
        check_eq("rst_dir_esq_en", int'({direita, esquerda, enable_mov}), 0);
        check_eq("rst_medir", int'(medir), 0);
        check_eq("rst_pulsos", int'({amostra_valida, timeout}), 0);
        check_eq("rst_erro_ativo", int'({erro_mov, ativo}), 0);
        check_eq("rst_pos_medida", int'(pos_medida), 0);
        check_eq("pos_inicial", int'(pos_inicial), 0);
        reset = 1'b0;

        // Start: set_pos, confirm, 4 settle cycles, then medir at position 0
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        check_eq("zera_set_pos", int'(set_pos), 1);
        check_eq("zera_db_estado", int'(db_estado), 1);
        iniciar = 1'b0;
        @(negedge clock);
        check_eq("set_pos_1ciclo", int'(set_pos), 0);
        repeat (4) @(negedge clock);
        check_eq("settle_sem_medir", int'(medir), 0);
        @(negedge clock);
        check_eq("medir_apos_settle", int'(medir), 1);
        @(negedge clock);
        check_eq("medir_pulso", int'(medir), 0);
        check_eq("pos_medida_0", int'(pos_medida), 0);

        // Ping-pong sweep
        foreach (tags_pp[k]) begin
            wait_evento(tag, kind);
            check_eq($sformatf("pp_tipo_%0d", k), kind, 1);
            check_eq($sformatf("pp_tag_%0d", k), tag, tags_pp[k]);
        end
        check_eq("esquerda_apos_tag3", esq_idx, 4);

        // Timeout at position 2
        resp_en = 1'b0;
        wait_medir(achou);
        check_eq("medir_tmo_visto", achou, 1);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            cyc++;
            if (timeout) break;
        end
        check_eq("timeout_8ciclos", cyc, 8);
        check_eq("timeout_tag", int'(pos_medida), 2);
        check_eq("timeout_sem_amostra", int'(amostra_valida), 0);
        resp_en = 1'b1;
        resp_delay = 8;

        // Simultaneous terminal count and measurement at position 3
        wait_evento(tag, kind);
        check_eq("simul_tipo", kind, 1);
        check_eq("simul_tag", tag, 3);
        resp_delay = 3;

        wait_evento(tag, kind);
        check_eq("desc_tag", tag, 2);

        // Stop during AGUARDA at position 1
        wait_medir(achou);
        check_eq("medir_parar_visto", achou, 1);
        @(negedge clock);
        parar = 1'b1;
        wait_evento(tag, kind);
        check_eq("parar_tipo", kind, 1);
        check_eq("parar_tag", tag, 1);
        @(negedge clock);
        check_eq("parar_ocioso", int'(db_estado), 0);
        check_eq("parar_ativo", int'(ativo), 0);
        check_eq("parar_alvo", int'(dut.alvo_q), 1);
        parar = 1'b0;

        // Move error with frozen servo
        freeze  = 1'b1;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        wait_evento(tag, kind);
        check_eq("erro_pre_tag", tag, 0);
        wait_estado(3, achou);
        check_eq("erro_confirma_visto", achou, 1);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (db_estado == 4'd3) cnt++;
            else break;
        end
        check_eq("erro_ciclos_confirma", cnt, 6);
        check_eq("erro_estado", int'(db_estado), 15);
        check_eq("erro_mov", int'(erro_mov), 1);
        check_eq("erro_ativo", int'(ativo), 0);
        iniciar = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("erro_ignora_iniciar", int'(db_estado), 15);
        check_eq("erro_mov_sticky", int'(erro_mov), 1);
        iniciar = 1'b0;

        // Mid-operation reset while settling on the way down
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("rst2_erro_mov", int'(erro_mov), 0);
        reset   = 1'b0;
        freeze  = 1'b0;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_evento(tag, kind);
            check_eq($sformatf("rst2_tag_%0d", k), tag, k);
        end
        wait_estado(4, achou);
        check_eq("rst2_estabiliza_visto", achou, 1);
        check_eq("rst2_sentido_desc", int'(dut.sentido_q), 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("rst2_ocioso", int'(db_estado), 0);
        check_eq("rst2_sentido", int'(dut.sentido_q), 1);
        check_eq("rst2_alvo", int'(dut.alvo_q), 0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (medir) cnt++;
        end
        check_eq("rst2_sem_medir", cnt, 0);
        check_eq("rst2_fica_ocioso", int'(db_estado), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
